// File: rtl/pwm_audio_out_pkg.sv
// Shared types and helpers for the PWM audio output stage.
// step_toward is sized wide so stages with any duty width up to 16 bits can reuse it.
package pwm_audio_out_pkg;

    localparam int DW_DEF = 6;
    localparam int PERIOD = (2 ** DW_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Moves cur toward target by at most max_step and never overshoots.
    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] target,
                                                input int          max_step);
        logic signed [16:0] diff;
        logic signed [16:0] lim;
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        lim  = 17'(max_step);
        if (diff > lim)
            return cur + lim[15:0];
        else if (diff < -lim)
            return cur - lim[15:0];
        else
            return target;
    endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Duty-stream input and PWM drive/status outputs of the audio output stage.
interface pwm_audio_out_if #(
    parameter int DW = 6
);
    logic          enable;
    logic [DW-1:0] duty_in;
    logic          pwm_out;
    logic          period_strobe;
    logic [DW-1:0] duty_eff;
    logic          busy;

    modport master (
        output enable, duty_in,
        input  pwm_out, period_strobe, duty_eff, busy
    );

    modport slave (
        input  enable, duty_in,
        output pwm_out, period_strobe, duty_eff, busy
    );
endinterface

// File: rtl/pwm_audio_out_tick_divider.sv
// Free-running prescaler: o_tick is high one cycle in every PRESCALE (constant high for 1).
// The first tick after reset release lands PRESCALE cycles later.
module pwm_audio_out_tick_divider #(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_last)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/pwm_audio_out.sv
// PWM output stage: duty is latched only at period wraps, slew-limited per period,
// and ramped to zero before going idle so the pin never clicks or glitches.
module pwm_audio_out
    import pwm_audio_out_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int PRESCALE = 1,
    parameter int MAX_STEP = 4
) (
    input  logic            i_sysclk,
    input  logic            i_reset,
    pwm_audio_out_if.slave  bus
);
    localparam logic [DW-1:0] CNT_LAST = DW'((2 ** DW) - 2);

    state_t        r_state;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_duty_eff;
    logic          r_pwm;
    logic          r_strobe;

    logic          w_tick;
    logic          w_wrap;
    logic [DW-1:0] w_cnt_inc;
    logic [DW-1:0] w_target;
    logic [DW-1:0] w_duty_next;
    state_t        w_state_next;

    pwm_audio_out_tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .i_clk  (i_sysclk),
        .i_rst  (i_reset),
        .o_tick (w_tick)
    );

    // Wrap decision: IDLE starts a period on any enabled tick, running states on the last count.
    always_comb begin
        w_wrap       = 1'b0;
        w_cnt_inc    = r_cnt + DW'(1);
        w_target     = bus.enable ? bus.duty_in : '0;
        w_duty_next  = DW'(step_toward(16'(r_duty_eff), 16'(w_target), MAX_STEP));
        w_state_next = r_state;

        if (w_tick) begin
            if (r_state == IDLE)
                w_wrap = bus.enable;
            else
                w_wrap = (r_cnt == CNT_LAST);
        end

        if (bus.enable)
            w_state_next = RUN;
        else if (r_state == RUN)
            w_state_next = DRAIN;
        else if (w_duty_next == '0)
            w_state_next = IDLE;
        else
            w_state_next = DRAIN;
    end

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_duty_eff <= '0;
            r_pwm      <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_wrap) begin
                r_state    <= w_state_next;
                r_cnt      <= '0;
                r_duty_eff <= w_duty_next;
                r_strobe   <= (w_state_next != IDLE);
                // cnt restarts at 0, so the first tick is high for any nonzero duty
                r_pwm      <= (w_state_next != IDLE) && (w_duty_next != '0);
            end else if (w_tick && (r_state != IDLE)) begin
                r_cnt <= w_cnt_inc;
                r_pwm <= (w_cnt_inc < r_duty_eff);
            end
        end
    end

    assign bus.pwm_out       = r_pwm;
    assign bus.period_strobe = r_strobe;
    assign bus.duty_eff      = r_duty_eff;
    assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_pwm_audio_out.sv
// Randomized bench for pwm_audio_out: two instances (PRESCALE 1 and 3) share the stimulus and
// are compared every cycle against a time-based model of the period/ramp rules.
module tb_pwm_audio_out;
    import pwm_audio_out_pkg::*;

    localparam int MS = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       r_en  = 1'b0;
    logic [5:0] r_duty = '0;

    pwm_audio_out_if #(.DW(6)) bus1 ();
    pwm_audio_out_if #(.DW(6)) bus3 ();

    assign bus1.enable  = r_en;
    assign bus1.duty_in = r_duty;
    assign bus3.enable  = r_en;
    assign bus3.duty_in = r_duty;

    pwm_audio_out #(.DW(6), .PRESCALE(1), .MAX_STEP(MS)) u_dut1 (
        .i_sysclk (clk),
        .i_reset  (rst),
        .bus      (bus1)
    );

    pwm_audio_out #(.DW(6), .PRESCALE(3), .MAX_STEP(MS)) u_dut3 (
        .i_sysclk (clk),
        .i_reset  (rst),
        .bus      (bus3)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model: 0=idle 1=run 2=drain; m_t counts edges since reset release, m_wt is the last wrap edge.
    int pre  [2] = '{1, 3};
    int m_t  [2];
    int m_st [2];
    int m_wt [2];
    int m_eff[2];

    function automatic int obs(input int k);
        if (k == 0)
            return int'({bus1.pwm_out, bus1.period_strobe, bus1.busy, bus1.duty_eff});
        else
            return int'({bus3.pwm_out, bus3.period_strobe, bus3.busy, bus3.duty_eff});
    endfunction

    function automatic int exp_out(input int k);
        int pwm, stb, bsy;
        bsy = (m_st[k] != 0) ? 1 : 0;
        stb = (bsy == 1 && m_t[k] == m_wt[k]) ? 1 : 0;
        pwm = (bsy == 1 && ((m_t[k] - m_wt[k]) / pre[k]) < m_eff[k]) ? 1 : 0;
        return (pwm << 8) | (stb << 7) | (bsy << 6) | m_eff[k];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k] = 0; m_st[k] = 0; m_wt[k] = 0; m_eff[k] = 0;
            end else begin
                bit tick, wrap;
                m_t[k]++;
                tick = (m_t[k] % pre[k]) == 0;
                if (m_st[k] == 0)
                    wrap = tick && r_en;
                else
                    wrap = tick && ((m_t[k] - m_wt[k]) / pre[k] == PERIOD);
                if (wrap) begin
                    int tgt, d;
                    tgt = r_en ? int'(r_duty) : 0;
                    d   = tgt - m_eff[k];
                    if (d > MS)       m_eff[k] += MS;
                    else if (d < -MS) m_eff[k] -= MS;
                    else              m_eff[k] = tgt;
                    if (r_en)              m_st[k] = 1;
                    else if (m_st[k] == 1) m_st[k] = 2;
                    else if (m_eff[k] == 0) m_st[k] = 0;
                    else                   m_st[k] = 2;
                    m_wt[k] = m_t[k];
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cyc_P1", obs(0), exp_out(0));
        chk("cyc_P3", obs(1), exp_out(1));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Length in sysclk and pwm-high cycles of one full period, strobe to strobe.
    task automatic measure(input int k, output int len, output int hi);
        int guard;
        guard = 0; len = 0; hi = 0;
        while (((obs(k) >> 7) & 1) == 0 && guard < 1000) begin
            step(); guard++;
        end
        if (guard >= 1000) begin
            chk("strobe_timeout", 0, 1);
            return;
        end
        len = 1; hi = (obs(k) >> 8) & 1;
        step();
        while (((obs(k) >> 7) & 1) == 0 && len < 1000) begin
            len++; hi += (obs(k) >> 8) & 1;
            step();
        end
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_P1"}, obs(0), 0);
        chk({tag, "_P3"}, obs(1), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int len, hi;
        r_en = 1'b1; r_duty = 6'd40;
        #1 rst = 1'b1;
        run(4);
        rst = 1'b0;

        // ramp to full scale, then stay continuously high
        r_duty = 6'd63;
        run(17 * 63 + 50);
        chk("full_eff", int'(bus1.duty_eff), 63);
        chk("full_pwm", int'(bus1.pwm_out), 1);

        r_duty = 6'd20;
        run(14 * 189);
        measure(0, len, hi);
        chk("d20_len", len, 63);
        chk("d20_hi", hi, 20);

        run(30);
        r_duty = 6'd22;
        run(3 * 189);
        r_duty = 6'd0;
        run(7 * 189);

        r_duty = 6'd10;
        run(4 * 189);
        r_en = 1'b0;
        run(63 + 20);
        r_en = 1'b1;
        run(2 * 189);
        r_en = 1'b0;
        run(5 * 189);
        chk("idle_busy", int'(bus1.busy), 0);

        r_en = 1'b1; r_duty = 6'd5;
        run(4 * 189);
        measure(1, len, hi);
        chk("p3_len", len, 189);
        chk("p3_hi", hi, 15);

        run(40);
        async_reset("mid_rst");

        repeat (40) begin
            r_en   = ($urandom_range(0, 3) != 0);
            r_duty = 6'($urandom_range(0, 63));
            run($urandom_range(1, 400));
            if ($urandom_range(0, 15) == 0)
                async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
